proc_pkt_arbiter: RTL and testbench
===================================

# proc_pkt_arbiter

Parametrised multi-requester front end for the GLB processor packet port. Arbitrates NUM_CH independent processor request channels round-robin onto the single GLB write/read packet interface. Tracks outstanding reads in an in-order tag FIFO so each read response returns to the channel that issued it. Sits between the processor-side crossbar and the GLB processor port.

## Interface
- NUM_CH, 4: number of requester channels (≥2)
- BANK_DATA_WIDTH, 64: packet data width
- GLB_ADDR_WIDTH, 22: packet address width
- MAX_OUTSTANDING, 8: tag FIFO depth, i.e. maximum reads in flight (power of two)
- Clock/reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- ch_req_valid  in  NUM_CH  per-channel request valid
- ch_req_ready  out  NUM_CH  per-channel accept (combinational)
- ch_req_wr  in  NUM_CH  1 = write, 0 = read
- ch_req_addr  in  NUM_CH*GLB_ADDR_WIDTH  packed addresses, channel i at [i*W +: W]
- ch_req_strb  in  NUM_CH*BANK_DATA_WIDTH/8  packed write strobes
- ch_req_data  in  NUM_CH*BANK_DATA_WIDTH  packed write data
- ch_rd_data  out  BANK_DATA_WIDTH  shared read response data
- ch_rd_data_valid  out  NUM_CH  one-hot response valid
- wr_en, wr_strb, wr_addr, wr_data  out  1, BANK_DATA_WIDTH/8, GLB_ADDR_WIDTH, BANK_DATA_WIDTH  GLB write packet
- rd_en, rd_addr  out  1, GLB_ADDR_WIDTH  GLB read packet
- rd_data, rd_data_valid  in  BANK_DATA_WIDTH, 1  GLB read response (in order)
- rd_outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight
- err_unexpected_rd  out  1  sticky: response arrived with tag FIFO empty

## Operation
- Eligibility: channel i eligible when ch_req_valid[i] & (ch_req_wr[i] | rd_outstanding < MAX_OUTSTANDING). Reads are masked while the FIFO is full; writes are never masked.
- Arbitration: round-robin over eligible channels, starting search at rr_ptr. Exactly one grant per cycle, at most. ch_req_ready[i] = grant[i].
- Acceptance: valid & ready. On acceptance, rr_ptr <= granted index + 1, wrapping from NUM_CH-1 to 0. rr_ptr holds when nothing is accepted.
- Write accept: next cycle, wr_en=1 with that channel's addr/strb/data.
- Read accept: next cycle, rd_en=1 with that channel's addr. Channel index is pushed into the tag FIFO in the acceptance cycle.
- wr_en and rd_en are never both 1. Each is a one-cycle pulse per accepted request.
- When idle, enables are 0 and addr/data/strb hold their last value.
- Response: on rd_data_valid, pop tag t. Next cycle, ch_rd_data = rd_data and ch_rd_data_valid = one-hot(t). Otherwise ch_rd_data_valid = 0 and ch_rd_data holds.
- Empty-pop: rd_data_valid with the FIFO empty sets err_unexpected_rd. The response is discarded: no ch_rd_data_valid, no pointer or count change.
- rd_outstanding: +1 on read accept, −1 on pop. Both in the same cycle leaves it unchanged.
- Full FIFO with a same-cycle pop: reads stay masked that cycle (eligibility uses the registered count). The slot frees the following cycle.

## Timing
- Reset values (reset_n=0 at posedge): wr_en=0, rd_en=0, wr_*/rd_addr=0, ch_rd_data=0, ch_rd_data_valid=0, rd_outstanding=0, err_unexpected_rd=0, rr_ptr=0, FIFO pointers=0.
- ch_req_ready is forced to 0 while reset_n=0.
- Reset mid-operation drops all in-flight tags. Later GLB responses hit an empty FIFO and set err_unexpected_rd.
- Request latency: accept at cycle N → GLB enable at N+1.
- Response latency: rd_data_valid at cycle M → ch_rd_data_valid at M+1.
- Throughput: one request per cycle sustained; one response per cycle sustained.
- FIFO pointers are log2(MAX_OUTSTANDING) bits and wrap naturally. Full/empty are derived from the count.

## Test plan
- Single write: ch2 requests write, addr 0x100, strb 0xFF, data 0xDEADBEEF. Required: ready[2]=1 the same cycle; next cycle wr_en=1, wr_addr=0x100, wr_data=0xDEADBEEF, rd_en=0.
- Round-robin fairness: all 4 channels hold valid for 8 cycles after reset. Required: grant order 0,1,2,3,0,1,2,3; one wr_en/rd_en pulse per cycle.
- Read routing: ch1 reads 0x10, then ch3 reads 0x20. GLB returns 0xAA, then 0xBB. Required: ch_rd_data_valid=0b0010 with 0xAA, then 0b1000 with 0xBB, each one cycle after rd_data_valid. rd_outstanding goes 1,2,1,0.
- Full FIFO: issue 8 reads with no responses. Required: 9th read gets ready=0 while a concurrent write on another channel is accepted. One response frees a slot; the read is accepted the cycle after the pop.
- Unexpected response: rd_data_valid=1 with rd_outstanding=0. Required: err_unexpected_rd=1 sticky, no ch_rd_data_valid, count stays 0.
- Reset mid-flight: 3 reads outstanding, pulse reset_n low 1 cycle. Required: all outputs return to reset values and rd_outstanding=0. The subsequent GLB response sets err_unexpected_rd.

Source files
------------

// File: rtl/proc_pkt_arbiter_if.sv
// Packet bundle between processor-side channels, the arbiter and the GLB port.
// The arbiter connects through the slave modport; the driving environment uses master.
interface proc_pkt_arbiter_if #(
  parameter int NUM_CH          = 4,
  parameter int BANK_DATA_WIDTH = 64,
  parameter int GLB_ADDR_WIDTH  = 22,
  parameter int MAX_OUTSTANDING = 8
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_CH-1:0]                     ch_req_valid;
  logic [NUM_CH-1:0]                     ch_req_ready;
  logic [NUM_CH-1:0]                     ch_req_wr;
  logic [NUM_CH*GLB_ADDR_WIDTH-1:0]      ch_req_addr;
  logic [NUM_CH*BANK_DATA_WIDTH/8-1:0]   ch_req_strb;
  logic [NUM_CH*BANK_DATA_WIDTH-1:0]     ch_req_data;
  logic [BANK_DATA_WIDTH-1:0]            ch_rd_data;
  logic [NUM_CH-1:0]                     ch_rd_data_valid;
  logic                                  wr_en;
  logic [BANK_DATA_WIDTH/8-1:0]          wr_strb;
  logic [GLB_ADDR_WIDTH-1:0]             wr_addr;
  logic [BANK_DATA_WIDTH-1:0]            wr_data;
  logic                                  rd_en;
  logic [GLB_ADDR_WIDTH-1:0]             rd_addr;
  logic [BANK_DATA_WIDTH-1:0]            rd_data;
  logic                                  rd_data_valid;
  logic [CW-1:0]                         rd_outstanding;
  logic                                  err_unexpected_rd;

  modport slave (
    input  ch_req_valid, ch_req_wr, ch_req_addr, ch_req_strb, ch_req_data,
    input  rd_data, rd_data_valid,
    output ch_req_ready, ch_rd_data, ch_rd_data_valid,
    output wr_en, wr_strb, wr_addr, wr_data, rd_en, rd_addr,
    output rd_outstanding, err_unexpected_rd
  );

  modport master (
    output ch_req_valid, ch_req_wr, ch_req_addr, ch_req_strb, ch_req_data,
    output rd_data, rd_data_valid,
    input  ch_req_ready, ch_rd_data, ch_rd_data_valid,
    input  wr_en, wr_strb, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_outstanding, err_unexpected_rd
  );
endinterface

// File: rtl/proc_pkt_arbiter.sv
// Round-robin front end merging NUM_CH processor request channels onto one GLB
// packet port; an in-order tag FIFO steers each read response back to its issuer.
module proc_pkt_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int BANK_DATA_WIDTH = 64,
  parameter int GLB_ADDR_WIDTH  = 22,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  proc_pkt_arbiter_if.slave pkt_if
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = BANK_DATA_WIDTH / 8;
  localparam int AW = GLB_ADDR_WIDTH;
  localparam int DW = BANK_DATA_WIDTH;

  // Index arithmetic modulo NUM_CH, which need not be a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned sum;
    int unsigned wrapped;
    sum     = 32'(base) + off;
    wrapped = (sum >= 32'(NUM_CH)) ? (sum - 32'(NUM_CH)) : sum;
    return wrapped[IW-1:0];
  endfunction

  logic [NUM_CH-1:0] elig_s;
  logic [NUM_CH-1:0] grant_s;
  logic              gnt_any_s;
  logic [IW-1:0]     gnt_idx_s;
  logic [IW-1:0]     cand_s;
  logic              sel_wr_s;
  logic [AW-1:0]     sel_addr_s;
  logic [SW-1:0]     sel_strb_s;
  logic [DW-1:0]     sel_data_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              unexp_s;
  logic [IW-1:0]     pop_tag_s;
  logic [NUM_CH-1:0] rsp_onehot_s;

  logic [IW-1:0]     rr_ptr_q;
  logic              wr_en_q;
  logic [SW-1:0]     wr_strb_q;
  logic [AW-1:0]     wr_addr_q;
  logic [DW-1:0]     wr_data_q;
  logic              rd_en_q;
  logic [AW-1:0]     rd_addr_q;
  logic [DW-1:0]     ch_rd_data_q;
  logic [NUM_CH-1:0] ch_rd_data_valid_q;
  logic [CW-1:0]     cnt_q;
  logic              err_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [IW-1:0]     tag_mem_q [MAX_OUTSTANDING];

  // Eligibility uses the registered count, so a full FIFO masks reads even in a pop cycle.
  assign full_s  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign empty_s = (cnt_q == {CW{1'b0}});
  assign elig_s  = pkt_if.ch_req_valid & (pkt_if.ch_req_wr | {NUM_CH{~full_s}}) & {NUM_CH{reset_n}};

  // Round-robin search starting at rr_ptr_q; first eligible channel wins.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    cand_s    = '0;
    grant_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s = wrap_add(rr_ptr_q, 32'(k));
      if (!gnt_any_s && elig_s[cand_s]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = cand_s;
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    if (gnt_any_s) begin
      grant_s[gnt_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign sel_wr_s   = pkt_if.ch_req_wr[gnt_idx_s];
  assign sel_addr_s = pkt_if.ch_req_addr[gnt_idx_s*AW +: AW];
  assign sel_strb_s = pkt_if.ch_req_strb[gnt_idx_s*SW +: SW];
  assign sel_data_s = pkt_if.ch_req_data[gnt_idx_s*DW +: DW];

  assign push_s    = gnt_any_s & ~sel_wr_s;
  assign pop_s     = pkt_if.rd_data_valid & ~empty_s;
  assign unexp_s   = pkt_if.rd_data_valid & empty_s;
  assign pop_tag_s = tag_mem_q[rd_ptr_q];

  // One-hot response steering for the channel at the head of the tag FIFO.
  always_comb begin
    rsp_onehot_s = '0;
    if (pop_s) begin
      rsp_onehot_s[pop_tag_s] = 1'b1;
    end else begin
      rsp_onehot_s = '0;
    end
  end

  // Main state: GLB packet registers, response registers, pointers and counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q           <= '0;
      wr_en_q            <= 1'b0;
      wr_strb_q          <= '0;
      wr_addr_q          <= '0;
      wr_data_q          <= '0;
      rd_en_q            <= 1'b0;
      rd_addr_q          <= '0;
      ch_rd_data_q       <= '0;
      ch_rd_data_valid_q <= '0;
      cnt_q              <= '0;
      err_q              <= 1'b0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
    end else begin
      wr_en_q            <= gnt_any_s & sel_wr_s;
      rd_en_q            <= push_s;
      ch_rd_data_valid_q <= rsp_onehot_s;
      if (gnt_any_s) begin
        rr_ptr_q <= wrap_add(gnt_idx_s, 32'd1);
      end
      if (gnt_any_s && sel_wr_s) begin
        wr_strb_q <= sel_strb_s;
        wr_addr_q <= sel_addr_s;
        wr_data_q <= sel_data_s;
      end
      if (push_s) begin
        rd_addr_q <= sel_addr_s;
        wr_ptr_q  <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        ch_rd_data_q <= pkt_if.rd_data;
        rd_ptr_q     <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (unexp_s) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      tag_mem_q[wr_ptr_q] <= gnt_idx_s;
    end
  end

  assign pkt_if.ch_req_ready      = grant_s;
  assign pkt_if.wr_en             = wr_en_q;
  assign pkt_if.wr_strb           = wr_strb_q;
  assign pkt_if.wr_addr           = wr_addr_q;
  assign pkt_if.wr_data           = wr_data_q;
  assign pkt_if.rd_en             = rd_en_q;
  assign pkt_if.rd_addr           = rd_addr_q;
  assign pkt_if.ch_rd_data        = ch_rd_data_q;
  assign pkt_if.ch_rd_data_valid  = ch_rd_data_valid_q;
  assign pkt_if.rd_outstanding    = cnt_q;
  assign pkt_if.err_unexpected_rd = err_q;
endmodule

// File: tb/tb_proc_pkt_arbiter.sv
// Directed bench for proc_pkt_arbiter: inputs change on the falling edge,
// registered outputs are sampled on the following falling edge.
module tb_proc_pkt_arbiter;
  localparam int NC = 4;
  localparam int DW = 64;
  localparam int AW = 22;
  localparam int MO = 8;
  localparam int SW = DW / 8;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  proc_pkt_arbiter_if #(.NUM_CH(NC), .BANK_DATA_WIDTH(DW), .GLB_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) bus ();

  proc_pkt_arbiter #(.NUM_CH(NC), .BANK_DATA_WIDTH(DW), .GLB_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pkt_if  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_inputs();
    bus.ch_req_valid  = '0;
    bus.ch_req_wr     = '0;
    bus.ch_req_addr   = '0;
    bus.ch_req_strb   = '0;
    bus.ch_req_data   = '0;
    bus.rd_data       = '0;
    bus.rd_data_valid = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [AW-1:0] addr,
                         input logic [SW-1:0] strb, input logic [DW-1:0] data);
    bus.ch_req_valid[ch]        = 1'b1;
    bus.ch_req_wr[ch]           = wr;
    bus.ch_req_addr[ch*AW +: AW] = addr;
    bus.ch_req_strb[ch*SW +: SW] = strb;
    bus.ch_req_data[ch*DW +: DW] = data;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clr_inputs();
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clr_inputs();
    bus.ch_req_valid = 4'b1111;
    @(negedge clk);
    #1;
    checks++; if (bus.ch_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", bus.ch_req_ready); end
    checks++; if ({bus.wr_en, bus.rd_en} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", {bus.wr_en, bus.rd_en}); end
    checks++; if (bus.wr_addr !== 22'h0 || bus.rd_addr !== 22'h0 || bus.wr_data !== 64'h0) begin errors++; $display("FAIL reset_bus: wr_addr %h rd_addr %h wr_data %h want 0", bus.wr_addr, bus.rd_addr, bus.wr_data); end
    checks++; if (bus.ch_rd_data_valid !== 4'b0000 || bus.ch_rd_data !== 64'h0) begin errors++; $display("FAIL reset_rsp: valid %b data %h want 0", bus.ch_rd_data_valid, bus.ch_rd_data); end
    checks++; if (bus.rd_outstanding !== 4'd0 || bus.err_unexpected_rd !== 1'b0) begin errors++; $display("FAIL reset_status: outst %0d err %b want 0 0", bus.rd_outstanding, bus.err_unexpected_rd); end
    clr_inputs();
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(2, 1'b1, 22'h100, 8'hFF, 64'h0000_0000_DEAD_BEEF);
    #1;
    checks++; if (bus.ch_req_ready !== 4'b0100) begin errors++; $display("FAIL single_write_ready: got %b want 0100", bus.ch_req_ready); end
    cycle();
    clr_inputs();
    checks++; if ({bus.wr_en, bus.rd_en} !== 2'b10) begin errors++; $display("FAIL single_write_en: got %b want 10", {bus.wr_en, bus.rd_en}); end
    checks++; if (bus.wr_addr !== 22'h100 || bus.wr_data !== 64'h0000_0000_DEAD_BEEF || bus.wr_strb !== 8'hFF) begin
      errors++; $display("FAIL single_write_pkt: addr %h data %h strb %h want 100 deadbeef ff", bus.wr_addr, bus.wr_data, bus.wr_strb); end
    cycle();
    checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 22'h100) begin errors++; $display("FAIL single_write_idle: wr_en %b addr %h want 0 100", bus.wr_en, bus.wr_addr); end
  endtask

  task automatic test_round_robin();
    logic [3:0]    exp_rdy;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] got_addr;
    logic [1:0]    exp_en;
    do_reset();
    for (int ch = 0; ch < NC; ch++) begin
      set_req(ch, (ch % 2) == 0, 22'h1000 + 22'(ch), 8'h0F, 64'(ch));
    end
    for (int k = 0; k < 8; k++) begin
      exp_rdy  = 4'b0001 << (k % 4);
      exp_addr = 22'h1000 + 22'(k % 4);
      exp_en   = ((k % 2) == 0) ? 2'b10 : 2'b01;
      #1;
      checks++; if (bus.ch_req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.ch_req_ready, exp_rdy); end
      cycle();
      got_addr = bus.wr_en ? bus.wr_addr : bus.rd_addr;
      checks++; if ({bus.wr_en, bus.rd_en} !== exp_en || got_addr !== exp_addr) begin
        errors++; $display("FAIL rr_pulse[%0d]: en %b addr %h want %b %h", k, {bus.wr_en, bus.rd_en}, got_addr, exp_en, exp_addr); end
    end
    clr_inputs();
    checks++; if (bus.rd_outstanding !== 4'd4) begin errors++; $display("FAIL rr_outstanding: got %0d want 4", bus.rd_outstanding); end
  endtask

  task automatic test_read_routing();
    do_reset();
    set_req(1, 1'b0, 22'h10, 8'h00, 64'h0);
    #1;
    checks++; if (bus.ch_req_ready !== 4'b0010) begin errors++; $display("FAIL route_ready1: got %b want 0010", bus.ch_req_ready); end
    cycle();
    checks++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 22'h10 || bus.rd_outstanding !== 4'd1) begin
      errors++; $display("FAIL route_rd1: en %b addr %h outst %0d want 1 10 1", bus.rd_en, bus.rd_addr, bus.rd_outstanding); end
    clr_inputs();
    set_req(3, 1'b0, 22'h20, 8'h00, 64'h0);
    cycle();
    clr_inputs();
    checks++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 22'h20 || bus.rd_outstanding !== 4'd2) begin
      errors++; $display("FAIL route_rd2: en %b addr %h outst %0d want 1 20 2", bus.rd_en, bus.rd_addr, bus.rd_outstanding); end
    bus.rd_data = 64'hAA; bus.rd_data_valid = 1'b1;
    cycle();
    checks++; if (bus.ch_rd_data_valid !== 4'b0010 || bus.ch_rd_data !== 64'hAA || bus.rd_outstanding !== 4'd1) begin
      errors++; $display("FAIL route_rsp1: valid %b data %h outst %0d want 0010 aa 1", bus.ch_rd_data_valid, bus.ch_rd_data, bus.rd_outstanding); end
    bus.rd_data = 64'hBB;
    cycle();
    checks++; if (bus.ch_rd_data_valid !== 4'b1000 || bus.ch_rd_data !== 64'hBB || bus.rd_outstanding !== 4'd0) begin
      errors++; $display("FAIL route_rsp2: valid %b data %h outst %0d want 1000 bb 0", bus.ch_rd_data_valid, bus.ch_rd_data, bus.rd_outstanding); end
    bus.rd_data_valid = 1'b0;
    cycle();
    checks++; if (bus.ch_rd_data_valid !== 4'b0000 || bus.ch_rd_data !== 64'hBB) begin
      errors++; $display("FAIL route_hold: valid %b data %h want 0000 bb", bus.ch_rd_data_valid, bus.ch_rd_data); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    for (int i = 0; i < MO; i++) begin
      set_req(0, 1'b0, 22'h200 + 22'(i), 8'h00, 64'h0);
      cycle();
    end
    clr_inputs();
    checks++; if (bus.rd_outstanding !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", bus.rd_outstanding); end
    set_req(1, 1'b0, 22'h3A0, 8'h00, 64'h0);
    set_req(2, 1'b1, 22'h3B0, 8'h3C, 64'h1234);
    #1;
    checks++; if (bus.ch_req_ready !== 4'b0100) begin errors++; $display("FAIL full_mask: got %b want 0100", bus.ch_req_ready); end
    cycle();
    checks++; if ({bus.wr_en, bus.rd_en} !== 2'b10 || bus.wr_addr !== 22'h3B0) begin
      errors++; $display("FAIL full_write: en %b addr %h want 10 3b0", {bus.wr_en, bus.rd_en}, bus.wr_addr); end
    bus.ch_req_valid[2] = 1'b0;
    bus.rd_data = 64'h55; bus.rd_data_valid = 1'b1;
    #1;
    checks++; if (bus.ch_req_ready !== 4'b0000) begin errors++; $display("FAIL full_pop_mask: got %b want 0000", bus.ch_req_ready); end
    cycle();
    bus.rd_data_valid = 1'b0;
    checks++; if (bus.ch_rd_data_valid !== 4'b0001 || bus.rd_outstanding !== 4'd7 || bus.rd_en !== 1'b0) begin
      errors++; $display("FAIL full_pop: valid %b outst %0d rd_en %b want 0001 7 0", bus.ch_rd_data_valid, bus.rd_outstanding, bus.rd_en); end
    #1;
    checks++; if (bus.ch_req_ready !== 4'b0010) begin errors++; $display("FAIL full_release: got %b want 0010", bus.ch_req_ready); end
    cycle();
    clr_inputs();
    checks++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 22'h3A0 || bus.rd_outstanding !== 4'd8) begin
      errors++; $display("FAIL full_late_read: en %b addr %h outst %0d want 1 3a0 8", bus.rd_en, bus.rd_addr, bus.rd_outstanding); end
  endtask

  task automatic test_unexpected();
    do_reset();
    bus.rd_data = 64'h77; bus.rd_data_valid = 1'b1;
    cycle();
    bus.rd_data_valid = 1'b0;
    checks++; if (bus.err_unexpected_rd !== 1'b1 || bus.ch_rd_data_valid !== 4'b0000 || bus.rd_outstanding !== 4'd0 || bus.ch_rd_data !== 64'h0) begin
      errors++; $display("FAIL unexp: err %b valid %b outst %0d data %h want 1 0000 0 0", bus.err_unexpected_rd, bus.ch_rd_data_valid, bus.rd_outstanding, bus.ch_rd_data); end
    cycle();
    checks++; if (bus.err_unexpected_rd !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %b want 1", bus.err_unexpected_rd); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int ch = 0; ch < 3; ch++) begin
      set_req(ch, 1'b0, 22'h40 + 22'(ch), 8'h00, 64'h0);
    end
    repeat (3) cycle();
    clr_inputs();
    checks++; if (bus.rd_outstanding !== 4'd3) begin errors++; $display("FAIL mid_count: got %0d want 3", bus.rd_outstanding); end
    reset_n = 1'b0;
    set_req(0, 1'b0, 22'h50, 8'h00, 64'h0);
    #1;
    checks++; if (bus.ch_req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: got %b want 0000", bus.ch_req_ready); end
    cycle();
    clr_inputs();
    reset_n = 1'b1;
    checks++; if (bus.rd_outstanding !== 4'd0 || bus.rd_en !== 1'b0 || bus.rd_addr !== 22'h0 || bus.err_unexpected_rd !== 1'b0) begin
      errors++; $display("FAIL mid_reset: outst %0d rd_en %b addr %h err %b want 0 0 0 0", bus.rd_outstanding, bus.rd_en, bus.rd_addr, bus.err_unexpected_rd); end
    bus.rd_data = 64'h99; bus.rd_data_valid = 1'b1;
    cycle();
    bus.rd_data_valid = 1'b0;
    checks++; if (bus.err_unexpected_rd !== 1'b1 || bus.ch_rd_data_valid !== 4'b0000) begin
      errors++; $display("FAIL mid_late_rsp: err %b valid %b want 1 0000", bus.err_unexpected_rd, bus.ch_rd_data_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_routing();
    test_full_fifo();
    test_unexpected();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
